// File: rtl/ram_pkg.sv
// Shared types and helpers for the single-clock simple-dual-port RAM with clear engine.
package ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  // Helpers work on a fixed maximum width; callers zero-extend in and size-cast out.
  localparam int FN_W = 512;

  function automatic logic [FN_W-1:0] lane_parity(input logic [FN_W-1:0] data,
                                                   input int bw);
    logic [FN_W-1:0] par;
    par = '0;
    for (int k = 0; k < FN_W; k++) begin
      par[k/bw] = par[k/bw] ^ data[k];
    end
    return par;
  endfunction

  function automatic logic [FN_W-1:0] merge_lanes(input logic [FN_W-1:0] old_w,
                                                   input logic [FN_W-1:0] new_w,
                                                   input logic [FN_W-1:0] be,
                                                   input int bw);
    logic [FN_W-1:0] res;
    res = old_w;
    for (int k = 0; k < FN_W; k++) begin
      if (be[k/bw]) res[k] = new_w[k];
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-output pipeline: LATENCY register stages for data, valid strobe and parity flags.
module ram_rd_pipe #(
  parameter int WIDTH   = 32,
  parameter int LANES   = 4,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LANES-1:0] in_perr,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [LANES-1:0] out_perr
);

  logic [LATENCY-1:0] vld;
  logic [WIDTH-1:0]   dat [LATENCY];
  logic [LANES-1:0]   per [LATENCY];

  // Data only advances with a valid beat so rd_data holds between reads;
  // parity flags are zero whenever their beat is not valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
      for (int s = 0; s < LATENCY; s++) begin
        dat[s] <= '0;
        per[s] <= '0;
      end
    end else begin
      vld[0] <= in_valid;
      if (in_valid) dat[0] <= in_data;
      per[0] <= in_valid ? in_perr : '0;
      for (int s = 1; s < LATENCY; s++) begin
        vld[s] <= vld[s-1];
        if (vld[s-1]) dat[s] <= dat[s-1];
        per[s] <= per[s-1];
      end
    end
  end

  assign out_valid = vld[LATENCY-1];
  assign out_data  = dat[LATENCY-1];
  assign out_perr  = per[LATENCY-1];

endmodule

// File: rtl/ram_sdp_clr.sv
// Single-clock simple-dual-port RAM with byte enables, read pipeline and clear engine.
// Optional per-lane even parity is enabled by defining RAM_PARITY_EN.
module ram_sdp_clr
  import ram_pkg::*;
#(
  parameter int                   RAM_WIDTH  = 32,
  parameter int                   BYTE_WIDTH = 8,
  parameter int                   RAM_DEPTH  = 512,
  parameter int                   ADDR_WIDTH = 9,
  parameter int                   RD_LATENCY = 1,
  parameter int                   RDW_MODE   = RDW_OLD,
  parameter logic [RAM_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clr_req,
  output logic                              init_busy,
  input  logic                              wr_en,
  input  logic [RAM_WIDTH/BYTE_WIDTH-1:0]   wr_be,
  input  logic [ADDR_WIDTH-1:0]             wr_addr,
  input  logic [RAM_WIDTH-1:0]              wr_data,
  input  logic                              rd_en,
  input  logic [ADDR_WIDTH-1:0]             rd_addr,
  output logic [RAM_WIDTH-1:0]              rd_data,
  output logic                              rd_valid,
  output logic [RAM_WIDTH/BYTE_WIDTH-1:0]   rd_perr,
  input  logic                              wr_perr_inj
);

  localparam int                    LANES     = RAM_WIDTH / BYTE_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH+1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("ram_sdp_clr: RD_LATENCY must be 1 or 2");
  end
  if (RAM_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $error("ram_sdp_clr: RAM_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (RAM_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("ram_sdp_clr: RAM_DEPTH exceeds the address space");
  end
  if (RAM_WIDTH > FN_W) begin : g_bad_fn_width
    $error("ram_sdp_clr: RAM_WIDTH exceeds helper function width");
  end

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  clearing;

  assign clearing  = (state == ST_CLEAR);
  assign init_busy = clearing;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clearing ? clr_cnt + 1'b1 : '0;
    end
  end

  // NOTE: next state defaults to the current state first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (clr_cnt == LAST_ADDR) state_nxt = ST_READY;
      ST_READY: if (clr_req) state_nxt = ST_CLEAR;
      default:  state_nxt = ST_CLEAR;
    endcase
  end

  // User port qualification; the clear engine owns the write port while clearing.
  logic wr_in_range, rd_in_range, user_we, user_re, rdw_hit;

  assign wr_in_range = {1'b0, wr_addr} < DEPTH_LIM;
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_LIM;
  assign user_we     = !clearing && wr_en && wr_in_range && (|wr_be);
  assign user_re     = !clearing && rd_en;
  assign rdw_hit     = (RDW_MODE == RDW_NEW) && user_we && (wr_addr == rd_addr);

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [RAM_WIDTH-1:0]  mem_wdata;
  logic [LANES-1:0]      mem_wbe;

  assign mem_we    = clearing || user_we;
  assign mem_waddr = clearing ? clr_cnt    : wr_addr;
  assign mem_wdata = clearing ? INIT_VALUE : wr_data;
  assign mem_wbe   = clearing ? '1         : wr_be;

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

  // NOTE: the array has no reset; the clear engine initialises it one word per cycle instead.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < LANES; i++) begin
        if (mem_wbe[i]) mem[mem_waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  logic [RAM_WIDTH-1:0] rd_old, rd_word;
  logic [LANES-1:0]     rd_par_err;

  // Out-of-range reads yield zero; write-first mode forwards the byte-merged write word.
  always_comb begin
    rd_old  = rd_in_range ? mem[rd_addr] : '0;
    rd_word = rd_old;
    if (rdw_hit) begin
      rd_word = RAM_WIDTH'(merge_lanes(FN_W'(rd_old), FN_W'(wr_data), FN_W'(wr_be), BYTE_WIDTH));
    end
  end

`ifdef RAM_PARITY_EN
  logic [LANES-1:0] par_mem [RAM_DEPTH];
  logic [LANES-1:0] wr_par, rd_par_old, rd_par;

  // Injection only ever reaches lanes that are actually written this cycle.
  assign wr_par = LANES'(lane_parity(FN_W'(mem_wdata), BYTE_WIDTH))
                ^ {LANES{!clearing && wr_perr_inj}};

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < LANES; i++) begin
        if (mem_wbe[i]) par_mem[mem_waddr][i] <= wr_par[i];
      end
    end
  end

  always_comb begin
    rd_par_old = rd_in_range ? par_mem[rd_addr] : '0;
    rd_par     = rd_par_old;
    if (rdw_hit) begin
      rd_par = LANES'(merge_lanes(FN_W'(rd_par_old), FN_W'(wr_par), FN_W'(wr_be), 1));
    end
    rd_par_err = rd_in_range ? (LANES'(lane_parity(FN_W'(rd_word), BYTE_WIDTH)) ^ rd_par) : '0;
  end
`else
  logic unused_perr_inj;
  assign unused_perr_inj = wr_perr_inj;
  assign rd_par_err      = '0;
`endif

  ram_rd_pipe #(
    .WIDTH  (RAM_WIDTH),
    .LANES  (LANES),
    .LATENCY(RD_LATENCY)
  ) u_rd_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (user_re),
    .in_data  (rd_word),
    .in_perr  (rd_par_err),
    .out_valid(rd_valid),
    .out_data (rd_data),
    .out_perr (rd_perr)
  );

endmodule

// File: tb/tb_ram_sdp_clr.sv
// Directed bench for ram_sdp_clr: three instances share stimulus (lat1/old, lat2/new, lat1/old depth 320).
module tb_ram_sdp_clr;

  localparam int W  = 32;
  localparam int BE = 4;
  localparam int AW = 9;
  localparam int DEPTH_C = 320;

`ifdef RAM_PARITY_EN
  localparam logic [BE-1:0] INJ_P = 4'b0010;
`else
  localparam logic [BE-1:0] INJ_P = 4'b0000;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, clr_req, wr_en, rd_en, wr_perr_inj;
  logic [BE-1:0] wr_be;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [W-1:0]  wr_data;

  logic          busy_a, valid_a, busy_b, valid_b, busy_c, valid_c;
  logic [W-1:0]  data_a, data_b, data_c;
  logic [BE-1:0] perr_a, perr_b, perr_c;

  int n_cmp = 0;
  int n_err = 0;

  ram_sdp_clr #(.RD_LATENCY(1), .RDW_MODE(0)) u_a (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .init_busy(busy_a),
    .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(data_a), .rd_valid(valid_a),
    .rd_perr(perr_a), .wr_perr_inj(wr_perr_inj)
  );

  ram_sdp_clr #(.RD_LATENCY(2), .RDW_MODE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .init_busy(busy_b),
    .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(data_b), .rd_valid(valid_b),
    .rd_perr(perr_b), .wr_perr_inj(wr_perr_inj)
  );

  ram_sdp_clr #(.RAM_DEPTH(DEPTH_C), .RD_LATENCY(1), .RDW_MODE(0)) u_c (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .init_busy(busy_c),
    .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(data_c), .rd_valid(valid_c),
    .rd_perr(perr_c), .wr_perr_inj(wr_perr_inj)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_be = '0; wr_perr_inj = 1'b0; rd_en = 1'b0; clr_req = 1'b0;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [W-1:0] d,
                       input logic [BE-1:0] be, input logic inj);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be; wr_perr_inj = inj;
    step();
    wr_en = 1'b0; wr_be = '0; wr_perr_inj = 1'b0;
  endtask

  // One read: a and c answer one cycle after the sampling edge, b one cycle later.
  task automatic read_check(input string tag, input logic [AW-1:0] a,
                            input logic [W-1:0] exp_a, input logic [W-1:0] exp_b,
                            input logic [BE-1:0] exp_p);
    logic [W-1:0]  exp_c;
    logic [BE-1:0] exp_cp;
    exp_c  = (int'(a) < DEPTH_C) ? exp_a : '0;
    exp_cp = (int'(a) < DEPTH_C) ? exp_p : '0;
    rd_en = 1'b1; rd_addr = a;
    step();
    rd_en = 1'b0;
    check({tag, ".a_valid"}, valid_a, 1);
    check({tag, ".a_data"}, data_a, exp_a);
    check({tag, ".a_perr"}, perr_a, exp_p);
    check({tag, ".c_valid"}, valid_c, 1);
    check({tag, ".c_data"}, data_c, exp_c);
    check({tag, ".c_perr"}, perr_c, exp_cp);
    check({tag, ".b_early"}, valid_b, 0);
    step();
    check({tag, ".b_valid"}, valid_b, 1);
    check({tag, ".b_data"}, data_b, exp_b);
    check({tag, ".b_perr"}, perr_b, exp_p);
    check({tag, ".a_single"}, valid_a, 0);
  endtask

  // Counts init_busy-high cycles from reset release (bounded) and flags rd_valid during the clear.
  task automatic wait_clear(input string tag);
    int cnt_a, cnt_b, cnt_c, bad;
    cnt_a = 0; cnt_b = 0; cnt_c = 0; bad = 0;
    for (int i = 0; i < 700; i++) begin
      if (busy_a) cnt_a++;
      if (busy_b) cnt_b++;
      if (busy_c) cnt_c++;
      if ((busy_a && valid_a) || (busy_b && valid_b) || (busy_c && valid_c)) bad++;
      if (!busy_a && !busy_b) break;
      step();
    end
    check({tag, ".busy_a"}, cnt_a, 512);
    check({tag, ".busy_b"}, cnt_b, 512);
    check({tag, ".busy_c"}, cnt_c, DEPTH_C);
    check({tag, ".valid_in_clear"}, bad, 0);
  endtask

  initial begin
    int stray;
    rst_n = 1'b0; idle(); wr_addr = '0; wr_data = '0;
    rd_en = 1'b1; rd_addr = 9'd5;
    step();
    step();
    check("rst.busy", busy_a, 1);
    check("rst.valid_a", valid_a, 0);
    check("rst.data_a", data_a, 0);
    check("rst.perr_a", perr_a, 0);
    check("rst.valid_b", valid_b, 0);
    check("rst.data_b", data_b, 0);
    rst_n = 1'b1;
    wait_clear("clear0");

    // rd_en has been held at addr 5 through the clear
    step();
    rd_en = 1'b0;
    check("post_clear.a_valid", valid_a, 1);
    check("post_clear.a_data", data_a, 0);
    check("post_clear.b_early", valid_b, 0);
    step();
    check("post_clear.b_valid", valid_b, 1);
    check("post_clear.b_data", data_b, 0);

    write(9'd3, 32'hDEAD_BEEF, 4'b1111, 1'b0);
    write(9'd3, 32'h1122_3344, 4'b0101, 1'b0);
    read_check("be_merge", 9'd3, 32'hDE22_BE44, 32'hDE22_BE44, 4'b0000);
    write(9'd3, 32'hFFFF_FFFF, 4'b0000, 1'b0);
    read_check("be_zero", 9'd3, 32'hDE22_BE44, 32'hDE22_BE44, 4'b0000);

    write(9'd0, 32'h1010_1010, 4'b1111, 1'b0);
    write(9'd1, 32'h2020_2020, 4'b1111, 1'b0);
    write(9'd2, 32'h3030_3030, 4'b1111, 1'b0);
    rd_en = 1'b1; rd_addr = 9'd0;
    step();
    check("pipe.n0_a", data_a, 32'h1010_1010);
    check("pipe.n0_bv", valid_b, 0);
    rd_addr = 9'd1;
    step();
    check("pipe.n1_a", data_a, 32'h2020_2020);
    check("pipe.n1_bv", valid_b, 1);
    check("pipe.n1_b", data_b, 32'h1010_1010);
    rd_addr = 9'd2;
    step();
    rd_en = 1'b0;
    check("pipe.n2_av", valid_a, 1);
    check("pipe.n2_a", data_a, 32'h3030_3030);
    check("pipe.n2_b", data_b, 32'h2020_2020);
    step();
    check("pipe.n3_av", valid_a, 0);
    check("pipe.n3_bv", valid_b, 1);
    check("pipe.n3_b", data_b, 32'h3030_3030);
    step();
    check("pipe.n4_bv", valid_b, 0);
    check("pipe.n4_bhold", data_b, 32'h3030_3030);
    check("pipe.n4_ahold", data_a, 32'h3030_3030);

    write(9'd7, 32'hAAAA_AAAA, 4'b1111, 1'b0);
    wr_en = 1'b1; wr_addr = 9'd7; wr_data = 32'h5555_5555; wr_be = 4'b0011;
    rd_en = 1'b1; rd_addr = 9'd7;
    step();
    idle();
    check("rdw.a_old", data_a, 32'hAAAA_AAAA);
    check("rdw.c_old", data_c, 32'hAAAA_AAAA);
    step();
    check("rdw.b_valid", valid_b, 1);
    check("rdw.b_new", data_b, 32'hAAAA_5555);
    read_check("rdw_after", 9'd7, 32'hAAAA_5555, 32'hAAAA_5555, 4'b0000);

    wr_en = 1'b1; wr_addr = 9'd8; wr_data = 32'h1234_5678; wr_be = 4'b1111;
    rd_en = 1'b1; rd_addr = 9'd7;
    step();
    idle();
    check("diff_addr.a", data_a, 32'hAAAA_5555);
    step();
    check("diff_addr.b", data_b, 32'hAAAA_5555);
    read_check("diff_addr8", 9'd8, 32'h1234_5678, 32'h1234_5678, 4'b0000);

    write(9'd400, 32'h0BAD_F00D, 4'b1111, 1'b0);
    read_check("oor", 9'd400, 32'h0BAD_F00D, 32'h0BAD_F00D, 4'b0000);

    // Clear request with a concurrent write and read, then a reset partway through the clear
    clr_req = 1'b1;
    wr_en = 1'b1; wr_addr = 9'd9; wr_data = 32'h9999_9999; wr_be = 4'b1111;
    rd_en = 1'b1; rd_addr = 9'd3;
    step();
    idle();
    check("clr.busy", busy_a, 1);
    check("clr.a_valid", valid_a, 1);
    check("clr.a_data", data_a, 32'hDE22_BE44);
    step();
    check("clr.b_valid", valid_b, 1);
    check("clr.b_data", data_b, 32'hDE22_BE44);
    stray = 0;
    for (int i = 0; i < 98; i++) begin
      step();
      if (!busy_a || !busy_b || valid_a || valid_b) stray++;
    end
    check("clr.hold", stray, 0);
    rst_n = 1'b0;
    step();
    check("midrst.busy", busy_a, 1);
    check("midrst.data_a", data_a, 0);
    check("midrst.data_b", data_b, 0);
    rst_n = 1'b1;
    wait_clear("restart");

    read_check("cleared9", 9'd9, 32'h0, 32'h0, 4'b0000);
    read_check("cleared3", 9'd3, 32'h0, 32'h0, 4'b0000);

    write(9'd2, 32'h0000_AB00, 4'b0010, 1'b1);
    read_check("perr_inj", 9'd2, 32'h0000_AB00, 32'h0000_AB00, INJ_P);
    read_check("perr_clean", 9'd4, 32'h0, 32'h0, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
